// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one pipelined 16-bit ALU among NREQ requesters.
// Divide-by-zero is answered locally; every other op is launched and its result is collected LAT edges later.
`timescale 1ns/1ps
module alu_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int LAT  = 4,
    parameter int IDW  = 2
) (
    input  logic                 c,
    input  logic                 r,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    output logic [3:0]           alu_s,
    output logic [15:0]          alu_x,
    output logic [15:0]          alu_y,
    input  logic [31:0]          alu_z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      alu_s_q, alu_s_d;
    logic [15:0]     alu_x_q, alu_x_d;
    logic [15:0]     alu_y_q, alu_y_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic              found_s;
    logic [IDW-1:0]    off_s;
    logic [IDW:0]      sum_s;
    logic [IDW-1:0]    win_s;
    logic [IDW-1:0]    nxt_ptr_s;
    logic [3:0]        op_s;
    logic [15:0]       x_s;
    logic [15:0]       y_s;
    logic              div0_s;

    // Rotating the valid vector by ptr turns the round-robin search into a plain lowest-index search.
    assign dbl_s = {req_valid, req_valid} >> ptr_q;
    assign rot_s = dbl_s[NREQ-1:0];

    // Lowest set bit of the rotated vector; walking downwards lets the smallest offset win.
    always_comb begin
        found_s = 1'b0;
        off_s   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            off_s   = rot_s[k] ? IDW'(k) : off_s;
            found_s = found_s | rot_s[k];
        end
    end

    assign sum_s     = {1'b0, ptr_q} + {1'b0, off_s};
    assign win_s     = (sum_s >= (IDW+1)'(NREQ)) ? IDW'(sum_s - (IDW+1)'(NREQ)) : sum_s[IDW-1:0];
    assign nxt_ptr_s = (win_s == IDW'(NREQ - 1)) ? '0 : win_s + IDW'(1);

    // Operand mux for the current winner.
    always_comb begin
        op_s = 4'd0;
        x_s  = 16'd0;
        y_s  = 16'd0;
        for (int i = 0; i < NREQ; i++) begin
            op_s = (win_s == IDW'(i)) ? req_op[4*i +: 4]  : op_s;
            x_s  = (win_s == IDW'(i)) ? req_x[16*i +: 16] : x_s;
            y_s  = (win_s == IDW'(i)) ? req_y[16*i +: 16] : y_s;
        end
    end

    assign div0_s    = (op_s == 4'd3) && (y_s == 16'd0);
    assign req_ready = (r && (state_q == IDLE) && found_s) ? ({{(NREQ-1){1'b0}}, 1'b1} << win_s) : '0;

    // Next-state and next-output logic for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        alu_s_d     = alu_s_q;
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    ptr_d    = nxt_ptr_s;
                    rsp_id_d = win_s;
                    if (div0_s) begin
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 32'd0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        alu_s_d = op_s;
                        alu_x_d = x_s;
                        alu_y_d = y_s;
                        cnt_d   = CW'(LAT - 1);
                        state_d = EXEC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = alu_z;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; everything clears with the ALU on r.
    always_ff @(negedge c or negedge r) begin
        if (!r) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            alu_s_q     <= 4'd0;
            alu_x_q     <= 16'd0;
            alu_y_q     <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            alu_s_q     <= alu_s_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_s     = alu_s_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: behavioural pipelined ALU on the same clock/reset,
// directed table and corner sequences, then random traffic checked against a round-robin scoreboard.
`timescale 1ns/1ps
module tb_alu_rr_scheduler;
    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int IDW  = 2;

    logic                c;
    logic                r;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_op;
    logic [16*NREQ-1:0]  req_x;
    logic [16*NREQ-1:0]  req_y;
    logic [3:0]          alu_s;
    logic [15:0]         alu_x;
    logic [15:0]         alu_y;
    logic [31:0]         alu_z;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_data;
    logic                rsp_err;
    logic                busy;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    int mptr     = 0;

    alu_rr_scheduler #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .c(c), .r(r),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_x(req_x), .req_y(req_y),
        .alu_s(alu_s), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    function automatic logic [31:0] alu_ref(input logic [3:0] s, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] a, b;
        a = {16'd0, x};
        b = {16'd0, y};
        case (s)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * b;
            4'd3:  return (y == 16'd0) ? 32'd0 : a / b;
            4'd4:  return (y == 16'd0) ? 32'd0 : a % b;
            4'd5:  return a & b;
            4'd6:  return a | b;
            4'd7:  return a ^ b;
            4'd8:  return a << y[3:0];
            4'd9:  return a >> y[3:0];
            4'd10: return {16'd0, ~x};
            4'd11: return (x < y) ? 32'd1 : 32'd0;
            4'd12: return {x, y};
            4'd13: return {y, x};
            default: return a;
        endcase
    endfunction

    // Pipelined ALU model: result appears LAT-1 edges after its operands, sampled on the LAT-th.
    logic [31:0] pipe [0:LAT-2];
    always @(negedge c or negedge r) begin
        if (!r) begin
            for (int k = 0; k < LAT - 1; k++) pipe[k] <= 32'd0;
        end else begin
            pipe[0] <= alu_ref(alu_s, alu_x, alu_y);
            for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign alu_z = pipe[LAT-2];

    always @(negedge c) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        return (i < 0) ? '0 : (NREQ'(1) << i);
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        logic [NREQ-1:0] t;
        for (int k = 0; k < NREQ; k++) begin
            t = v >> ((p + k) % NREQ);
            if (t[0]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        req_op[4*i +: 4]  = op;
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (req_ready == '0 && n < 50) begin tick(); n++; end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 30) begin tick(); n++; end
        chk("rsp_arrived", rsp_valid, 1);
    endtask

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] data;
        logic        err;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          edge_no;
    } exp_t;

    vec_t tv [11];
    exp_t sb [$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int te, prev_te, w, w2, gi;
        logic [3:0]  last_s;
        logic [15:0] last_x, last_y;
        logic [31:0] hold_data;
        logic [NREQ-1:0] drop_mask;
        logic rsp_seen;
        exp_t e;

        tv[0]  = '{1, 4'd0,  16'd3,     16'd5,     32'd8,          1'b0};
        tv[1]  = '{2, 4'd3,  16'd10,    16'd0,     32'd0,          1'b1};
        tv[2]  = '{2, 4'd3,  16'd10,    16'd3,     32'd3,          1'b0};
        tv[3]  = '{0, 4'd2,  16'd300,   16'd400,   32'd120000,     1'b0};
        tv[4]  = '{3, 4'd1,  16'd5,     16'd7,     32'hFFFF_FFFE,  1'b0};
        tv[5]  = '{1, 4'd7,  16'hF0F0,  16'h0FF0,  32'h0000_FF00,  1'b0};
        tv[6]  = '{0, 4'd8,  16'h8001,  16'd4,     32'h0008_0010,  1'b0};
        tv[7]  = '{3, 4'd12, 16'hABCD,  16'h1234,  32'hABCD_1234,  1'b0};
        tv[8]  = '{0, 4'd3,  16'hFFFF,  16'd0,     32'd0,          1'b1};
        tv[9]  = '{2, 4'd4,  16'd17,    16'd0,     32'd0,          1'b0};
        tv[10] = '{1, 4'd2,  16'hFFFF,  16'hFFFF,  32'hFFFE_0001,  1'b0};

        r = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_op = '0; req_x = '0; req_y = '0;

        // Reset with every requester asking, then fairness under continuous demand.
        for (int i = 0; i < NREQ; i++) set_req(i, 4'd2, 16'(i + 2), 16'd7);
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu", {alu_s, alu_x, alu_y}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_fields", {rsp_id, rsp_data, rsp_err}, 0);
        r = 1'b1; mptr = 0;
        #1;
        chk("rst_first_grant", req_ready, 4'b0001);
        prev_te = 0;
        for (int g = 0; g < 6; g++) begin
            wait_grant();
            chk("fair_grant", req_ready, oh(g % NREQ));
            te = edge_cnt + 1;
            if (g > 0) chk("fair_spacing", te - prev_te, LAT + 2);
            prev_te = te;
            mptr = (g % NREQ + 1) % NREQ;
            tick();
            if (g == 5) req_valid = '0;
            wait_rsp();
            chk("fair_id", rsp_id, g % NREQ);
            chk("fair_data", rsp_data, ((g % NREQ) + 2) * 7);
        end
        tick();
        rsp_ready = 1'b0;

        // Directed single transactions from an idle scheduler.
        last_s = 4'd2; last_x = 16'd3; last_y = 16'd7;
        foreach (tv[v]) begin
            set_req(tv[v].id, tv[v].op, tv[v].x, tv[v].y);
            req_valid = oh(tv[v].id);
            #1;
            chk("tbl_grant", req_ready, oh(tv[v].id));
            te = edge_cnt + 1;
            mptr = (tv[v].id + 1) % NREQ;
            tick();
            req_valid = '0;
            wait_rsp();
            chk("tbl_latency", edge_cnt - te, tv[v].err ? 0 : LAT);
            chk("tbl_id", rsp_id, tv[v].id);
            chk("tbl_data", rsp_data, tv[v].data);
            chk("tbl_err", rsp_err, tv[v].err);
            if (tv[v].err) begin
                chk("tbl_alu_hold", {alu_s, alu_x, alu_y}, {last_s, last_x, last_y});
            end else begin
                chk("tbl_alu_launch", {alu_s, alu_x, alu_y}, {tv[v].op, tv[v].x, tv[v].y});
                last_s = tv[v].op; last_x = tv[v].x; last_y = tv[v].y;
            end
            rsp_ready = 1'b1;
            tick();
            chk("tbl_accept", rsp_valid, 0);
            rsp_ready = 1'b0;
        end

        // Backpressure: response held while others wait.
        for (int i = 0; i < NREQ; i++) set_req(i, 4'd0, 16'(i * 100), 16'd1);
        req_valid = 4'b1101;
        #1;
        w = rr_pick(req_valid, mptr);
        chk("bp_grant", req_ready, oh(w));
        tick();
        req_valid[w] = 1'b0;
        mptr = (w + 1) % NREQ;
        wait_rsp();
        hold_data = 32'(w * 100 + 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("bp_rsp_hold", {rsp_valid, 30'(rsp_id), rsp_data, rsp_err}, {1'b1, 30'(w), hold_data, 1'b0});
            chk("bp_no_grant", req_ready, 0);
            chk("bp_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_accepted", {rsp_valid, busy}, 0);
        w2 = rr_pick(req_valid, mptr);
        chk("bp_next_grant", req_ready, oh(w2));

        // Reset in the middle of EXEC discards the transaction and restarts from requester 0.
        tick();
        req_valid[w2] = 1'b0;
        tick();
        tick();
        set_req(1, 4'd0, 16'd1, 16'd1);
        req_valid = 4'b1110;
        r = 1'b0;
        #1;
        chk("mid_rst_outputs", {rsp_valid, busy, alu_s, alu_x, alu_y, rsp_data}, 0);
        chk("mid_rst_ready", req_ready, 0);
        repeat (3) tick();
        chk("mid_rst_no_rsp", rsp_valid, 0);
        r = 1'b1; mptr = 0;
        #1;
        chk("mid_rst_restart", req_ready, 4'b0010);

        // Clean restart, then random traffic against the scoreboard.
        r = 1'b0; req_valid = '0;
        tick();
        r = 1'b1; mptr = 0;
        drop_mask = '0; rsp_seen = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge c);
            req_valid = req_valid & ~drop_mask;
            drop_mask = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (cyc < 1700 && !req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15)),
                            16'($urandom), ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (rsp_valid && !rsp_seen) begin
                chk("rnd_rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb[0];
                    chk("rnd_id", rsp_id, e.id);
                    chk("rnd_data", rsp_data, e.data);
                    chk("rnd_err", rsp_err, e.err);
                    chk("rnd_edge", edge_cnt, e.edge_no);
                end
                rsp_seen = 1'b1;
            end
            chk("rnd_busy", busy, sb.size() != 0);
            gi = (sb.size() == 0) ? rr_pick(req_valid, mptr) : -1;
            chk("rnd_grant", req_ready, oh(gi));
            if (gi >= 0) begin
                e.id  = gi;
                e.err = (req_op[4*gi +: 4] == 4'd3) && (req_y[16*gi +: 16] == 16'd0);
                e.data = e.err ? 32'd0 : alu_ref(req_op[4*gi +: 4], req_x[16*gi +: 16], req_y[16*gi +: 16]);
                e.edge_no = edge_cnt + 1 + (e.err ? 0 : LAT);
                sb.push_back(e);
                mptr = (gi + 1) % NREQ;
                drop_mask = oh(gi);
            end
            if (rsp_valid && rsp_ready && sb.size() != 0 && gi < 0) begin
                void'(sb.pop_front());
                rsp_seen = 1'b0;
            end
        end
        chk("rnd_drained_sb", sb.size(), 0);
        chk("rnd_drained_req", req_valid & ~drop_mask, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
